// File: rtl/cdf_extrema_tracker_if.sv
// Pixel-stream input and per-frame extrema result bundle for cdf_extrema_tracker.
// The slave modport is the tracker side; the master modport is the producer/consumer side.
interface cdf_extrema_tracker_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 1,
   parameter int CNT_WIDTH  = 19
);
   logic [NUM_CH*DATA_WIDTH-1:0] i_pixel;
   logic                         i_pixel_valid;
   logic                         i_sof;
   logic                         i_eof;
   logic [NUM_CH*DATA_WIDTH-1:0] o_min;
   logic [NUM_CH*CNT_WIDTH-1:0]  o_min_cnt;
   logic [NUM_CH*DATA_WIDTH-1:0] o_max;
   logic [NUM_CH*CNT_WIDTH-1:0]  o_max_cnt;
   logic                         o_stats_valid;
   logic                         i_stats_ready;
   logic                         o_overrun;
   logic                         o_frame_err;

   modport slave (
      input  i_pixel, i_pixel_valid, i_sof, i_eof, i_stats_ready,
      output o_min, o_min_cnt, o_max, o_max_cnt, o_stats_valid, o_overrun, o_frame_err
   );

   modport master (
      output i_pixel, i_pixel_valid, i_sof, i_eof, i_stats_ready,
      input  o_min, o_min_cnt, o_max, o_max_cnt, o_stats_valid, o_overrun, o_frame_err
   );
endinterface

// File: rtl/cdf_extrema_tracker.sv
// Per-frame, per-channel min/max tracker with occurrence counts (cdfMin source).
// Results are published on EOF and held on a valid/ready port while the next frame accumulates.
module cdf_extrema_tracker #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 1,
   parameter int CNT_WIDTH  = 19
) (
   input logic                  i_clk,
   input logic                  i_reset_n,
   cdf_extrema_tracker_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t state_r, state_s;
   logic   init_s, accum_s, publish_s, frame_err_s;
   logic   valid_r, overrun_r, frame_err_r;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      if (cnt == {CNT_WIDTH{1'b1}}) begin
         sat_inc = cnt;
      end else begin
         sat_inc = cnt + CNT_WIDTH'(1);
      end
   endfunction

   // Frame state register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode: a single-beat frame (SOF+EOF) never leaves IDLE
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.i_pixel_valid && bus.i_sof && !bus.i_eof) begin
               state_s = ACCUM;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (bus.i_pixel_valid && bus.i_eof) begin
               state_s = IDLE;
            end else begin
               state_s = ACCUM;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Control decode: an SOF inside a frame restarts accumulation from that beat
   always_comb begin
      init_s      = 1'b0;
      accum_s     = 1'b0;
      publish_s   = 1'b0;
      frame_err_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_pixel_valid && bus.i_sof) begin
               init_s    = 1'b1;
               publish_s = bus.i_eof;
            end else begin
               init_s = 1'b0;
            end
         end
         ACCUM: begin
            if (bus.i_pixel_valid) begin
               init_s      = bus.i_sof;
               frame_err_s = bus.i_sof;
               accum_s     = !bus.i_sof;
               publish_s   = bus.i_eof;
            end else begin
               publish_s = 1'b0;
            end
         end
         default: init_s = 1'b0;
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_WIDTH-1:0] smp_s;
      logic [DATA_WIDTH-1:0] wmin_r, wmin_s, wmax_r, wmax_s, omin_r, omax_r;
      logic [CNT_WIDTH-1:0]  wmin_cnt_r, wmin_cnt_s, wmax_cnt_r, wmax_cnt_s;
      logic [CNT_WIDTH-1:0]  omin_cnt_r, omax_cnt_r;

      assign smp_s = bus.i_pixel[k*DATA_WIDTH +: DATA_WIDTH];

      // Post-update working values; a flat sample bumps both counts
      always_comb begin
         wmin_s     = wmin_r;
         wmin_cnt_s = wmin_cnt_r;
         wmax_s     = wmax_r;
         wmax_cnt_s = wmax_cnt_r;
         if (init_s) begin
            wmin_s     = smp_s;
            wmin_cnt_s = CNT_WIDTH'(1);
            wmax_s     = smp_s;
            wmax_cnt_s = CNT_WIDTH'(1);
         end else if (accum_s) begin
            if (smp_s < wmin_r) begin
               wmin_s     = smp_s;
               wmin_cnt_s = CNT_WIDTH'(1);
            end else if (smp_s == wmin_r) begin
               wmin_cnt_s = sat_inc(wmin_cnt_r);
            end else begin
               wmin_s = wmin_r;
            end
            if (smp_s > wmax_r) begin
               wmax_s     = smp_s;
               wmax_cnt_s = CNT_WIDTH'(1);
            end else if (smp_s == wmax_r) begin
               wmax_cnt_s = sat_inc(wmax_cnt_r);
            end else begin
               wmax_s = wmax_r;
            end
         end else begin
            wmin_s = wmin_r;
         end
      end

      // Working accumulators and published copy
      always_ff @(posedge i_clk) begin
         if (!i_reset_n) begin
            wmin_r     <= '0;
            wmax_r     <= '0;
            wmin_cnt_r <= '0;
            wmax_cnt_r <= '0;
            omin_r     <= '0;
            omax_r     <= '0;
            omin_cnt_r <= '0;
            omax_cnt_r <= '0;
         end else begin
            wmin_r     <= wmin_s;
            wmax_r     <= wmax_s;
            wmin_cnt_r <= wmin_cnt_s;
            wmax_cnt_r <= wmax_cnt_s;
            if (publish_s) begin
               omin_r     <= wmin_s;
               omax_r     <= wmax_s;
               omin_cnt_r <= wmin_cnt_s;
               omax_cnt_r <= wmax_cnt_s;
            end
         end
      end

      assign bus.o_min[k*DATA_WIDTH +: DATA_WIDTH]   = omin_r;
      assign bus.o_max[k*DATA_WIDTH +: DATA_WIDTH]   = omax_r;
      assign bus.o_min_cnt[k*CNT_WIDTH +: CNT_WIDTH] = omin_cnt_r;
      assign bus.o_max_cnt[k*CNT_WIDTH +: CNT_WIDTH] = omax_cnt_r;
   end

   // Result handshake and one-cycle error pulses
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         valid_r     <= 1'b0;
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         overrun_r   <= publish_s && valid_r && !bus.i_stats_ready;
         frame_err_r <= frame_err_s;
         if (publish_s) begin
            valid_r <= 1'b1;
         end else if (bus.i_stats_ready) begin
            valid_r <= 1'b0;
         end
      end
   end

   assign bus.o_stats_valid = valid_r;
   assign bus.o_overrun     = overrun_r;
   assign bus.o_frame_err   = frame_err_r;
endmodule

// File: tb/tb_cdf_extrema_tracker.sv
// Self-checking bench for cdf_extrema_tracker (3 channels, 3-bit counters) against a
// frame-buffer reference model that computes extrema by scanning each finished frame.
module tb_cdf_extrema_tracker;
   localparam int DW     = 8;
   localparam int NC     = 3;
   localparam int CW     = 3;
   localparam int PW     = NC*DW;
   localparam int QW     = NC*CW;
   localparam int SAT    = (1 << CW) - 1;
   localparam int MAXLEN = 256;
   localparam int VW     = 2*PW + 2*QW + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   cdf_extrema_tracker_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) bus ();

   cdf_extrema_tracker #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // reference model state: samples of the open frame plus the published result
   logic          m_in_frame;
   int            m_len;
   int            m_buf[NC][MAXLEN];
   logic [PW-1:0] m_min, m_max;
   logic [QW-1:0] m_min_cnt, m_max_cnt;
   logic          m_valid, m_ovr, m_ferr;

   logic [VW-1:0] act_v, exp_v;
   assign act_v = {bus.o_min, bus.o_min_cnt, bus.o_max, bus.o_max_cnt,
                   bus.o_stats_valid, bus.o_overrun, bus.o_frame_err};
   assign exp_v = {m_min, m_min_cnt, m_max, m_max_cnt, m_valid, m_ovr, m_ferr};

   task automatic model_publish();
      int mn, mx, nmn, nmx;
      for (int c = 0; c < NC; c++) begin
         mn = 256; mx = -1; nmn = 0; nmx = 0;
         for (int i = 0; i < m_len; i++) begin
            if (m_buf[c][i] < mn) mn = m_buf[c][i];
            if (m_buf[c][i] > mx) mx = m_buf[c][i];
         end
         for (int i = 0; i < m_len; i++) begin
            if (m_buf[c][i] == mn) nmn++;
            if (m_buf[c][i] == mx) nmx++;
         end
         m_min[c*DW +: DW]     = DW'(mn);
         m_max[c*DW +: DW]     = DW'(mx);
         m_min_cnt[c*CW +: CW] = CW'((nmn > SAT) ? SAT : nmn);
         m_max_cnt[c*CW +: CW] = CW'((nmx > SAT) ? SAT : nmx);
      end
   endtask

   task automatic model_step(input logic v, input logic s, input logic e, input logic r,
                             input logic [PW-1:0] p);
      logic pub;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      pub    = 1'b0;
      if (!rst_n) begin
         m_in_frame = 1'b0; m_len = 0; m_valid = 1'b0;
         m_min = '0; m_max = '0; m_min_cnt = '0; m_max_cnt = '0;
      end else begin
         if (v) begin
            if (s) begin
               m_ferr     = m_in_frame;
               m_in_frame = 1'b1;
               m_len      = 0;
            end
            if (m_in_frame) begin
               if (m_len < MAXLEN) begin
                  for (int c = 0; c < NC; c++) m_buf[c][m_len] = int'(p[c*DW +: DW]);
                  m_len++;
               end
               if (e) begin
                  pub        = 1'b1;
                  m_in_frame = 1'b0;
               end
            end
         end
         if (pub) begin
            m_ovr = m_valid && !r;
            model_publish();
            m_valid = 1'b1;
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic r,
                        input logic [PW-1:0] p);
      bus.i_pixel_valid = v;
      bus.i_sof         = s;
      bus.i_eof         = e;
      bus.i_stats_ready = r;
      bus.i_pixel       = p;
      model_step(v, s, e, r, p);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] rnd_pix();
      logic [PW-1:0] p;
      for (int c = 0; c < NC; c++) p[c*DW +: DW] = DW'($urandom);
      return p;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 24'hABCDEF);
      total++;
      if (act_v !== '0) begin
         bad++; $display("FAIL reset_state got=%h exp=0", act_v);
      end
      total++;
      if (act_v !== exp_v) begin
         bad++; $display("FAIL reset_model got=%h exp=%h", act_v, exp_v);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int seq[6] = '{5, 3, 3, 9, 9, 9};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i == 0, i == 5, 1'b0, {DW'($urandom), DW'($urandom), DW'(seq[i])});
         total++;
         if (act_v !== exp_v) begin
            bad++; $display("FAIL basic_beat%0d got=%h exp=%h", i, act_v, exp_v);
         end
      end
      total++;
      if (bus.o_min[7:0] !== 8'd3 || bus.o_min_cnt[2:0] !== 3'd2 || bus.o_max[7:0] !== 8'd9 ||
          bus.o_max_cnt[2:0] !== 3'd3 || bus.o_stats_valid !== 1'b1) begin
         bad++; $display("FAIL basic_result got min=%0d/%0d max=%0d/%0d v=%b exp 3/2 9/3 v=1",
                         bus.o_min[7:0], bus.o_min_cnt[2:0], bus.o_max[7:0], bus.o_max_cnt[2:0],
                         bus.o_stats_valid);
      end
      repeat (3) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, rnd_pix());
         total++;
         if (act_v !== exp_v) begin
            bad++; $display("FAIL basic_hold got=%h exp=%h", act_v, exp_v);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
      total++;
      if (bus.o_stats_valid !== 1'b0 || act_v !== exp_v) begin
         bad++; $display("FAIL basic_accept got=%h exp=%h", act_v, exp_v);
      end
   endtask

   task automatic test_multi_ch();
      logic [PW-1:0] beats[4] = '{{8'd10, 8'd0, 8'd7}, {8'd2, 8'd255, 8'd7},
                                  {8'd2, 8'd0, 8'd7}, {8'd200, 8'd1, 8'd7}};
      for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i == 3, 1'b0, beats[i]);
      total++;
      if (bus.o_min !== {8'd2, 8'd0, 8'd7} || bus.o_min_cnt !== {3'd2, 3'd2, 3'd4} ||
          bus.o_max !== {8'd200, 8'd255, 8'd7} || bus.o_max_cnt !== {3'd1, 3'd1, 3'd4}) begin
         bad++; $display("FAIL multi_ch got min=%h/%h max=%h/%h", bus.o_min, bus.o_min_cnt,
                         bus.o_max, bus.o_max_cnt);
      end
      total++;
      if (act_v !== exp_v) begin
         bad++; $display("FAIL multi_ch_model got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
   endtask

   task automatic test_overrun();
      for (int f = 0; f < 2; f++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, rnd_pix());
         drive(1'b1, 1'b0, 1'b1, 1'b0, rnd_pix());
      end
      total++;
      if (bus.o_overrun !== 1'b1 || bus.o_stats_valid !== 1'b1 || act_v !== exp_v) begin
         bad++; $display("FAIL overrun_pulse got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, rnd_pix());
      total++;
      if (bus.o_overrun !== 1'b0 || bus.o_stats_valid !== 1'b1 || act_v !== exp_v) begin
         bad++; $display("FAIL overrun_single got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, rnd_pix());
      drive(1'b1, 1'b0, 1'b1, 1'b1, rnd_pix());
      total++;
      if (bus.o_overrun !== 1'b0 || bus.o_stats_valid !== 1'b1 || act_v !== exp_v) begin
         bad++; $display("FAIL overrun_accept got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
   endtask

   task automatic test_frame_err();
      int  vals[5] = '{1, 2, 50, 60, 40};
      logic sofs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, sofs[i], i == 4, 1'b0, {NC{DW'(vals[i])}});
         total++;
         if (bus.o_frame_err !== (i == 2) || act_v !== exp_v) begin
            bad++; $display("FAIL frame_err_beat%0d got=%h exp=%h", i, act_v, exp_v);
         end
      end
      total++;
      if (bus.o_min !== {NC{8'd40}} || bus.o_min_cnt !== {NC{3'd1}} ||
          bus.o_max !== {NC{8'd60}} || bus.o_max_cnt !== {NC{3'd1}}) begin
         bad++; $display("FAIL frame_err_result got min=%h/%h max=%h/%h", bus.o_min,
                         bus.o_min_cnt, bus.o_max, bus.o_max_cnt);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
   endtask

   task automatic test_single();
      drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_pix());
      drive(1'b1, 1'b0, 1'b1, 1'b0, rnd_pix());
      total++;
      if (bus.o_stats_valid !== 1'b0 || act_v !== exp_v) begin
         bad++; $display("FAIL single_presof got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, {NC{8'd128}});
      total++;
      if (bus.o_min !== {NC{8'd128}} || bus.o_max !== {NC{8'd128}} ||
          bus.o_min_cnt !== {NC{3'd1}} || bus.o_max_cnt !== {NC{3'd1}} ||
          bus.o_stats_valid !== 1'b1 || act_v !== exp_v) begin
         bad++; $display("FAIL single_beat got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 10; i++) drive(1'b1, i == 0, i == 9, 1'b0, {NC{8'd77}});
      total++;
      if (bus.o_min_cnt !== {NC{3'd7}} || bus.o_max_cnt !== {NC{3'd7}} || act_v !== exp_v) begin
         bad++; $display("FAIL saturation got cnt=%h/%h exp 7s", bus.o_min_cnt, bus.o_max_cnt);
      end
      for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 1'b0, rnd_pix());
      rst_n = 1'b0;
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_pix());
      total++;
      if (act_v !== '0) begin
         bad++; $display("FAIL reset_midframe got=%h exp=0", act_v);
      end
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 1'b0, rnd_pix());
      drive(1'b1, 1'b1, 1'b0, 1'b0, {8'd9, 8'd8, 8'd7});
      drive(1'b1, 1'b0, 1'b1, 1'b0, {8'd1, 8'd20, 8'd7});
      total++;
      if (bus.o_min !== {8'd1, 8'd8, 8'd7} || bus.o_min_cnt !== {3'd1, 3'd1, 3'd2} ||
          bus.o_max !== {8'd9, 8'd20, 8'd7} || bus.o_max_cnt !== {3'd1, 3'd1, 3'd2} ||
          act_v !== exp_v) begin
         bad++; $display("FAIL post_reset_frame got=%h exp=%h", act_v, exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_pix());
   endtask

   task automatic test_random();
      logic [PW-1:0] p;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NC; c++)
            p[c*DW +: DW] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1, p);
         total++;
         if (act_v !== exp_v) begin
            bad++; $display("FAIL random cyc=%0d got=%h exp=%h", n, act_v, exp_v);
         end
      end
   endtask

   initial begin
      bus.i_pixel_valid = 1'b0;
      bus.i_sof         = 1'b0;
      bus.i_eof         = 1'b0;
      bus.i_stats_ready = 1'b0;
      bus.i_pixel       = '0;
      #1;
      test_reset();
      test_basic();
      test_multi_ch();
      test_overrun();
      test_frame_err();
      test_single();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cdf_extrema_tracker.md
# cdf_extrema_tracker

Per-frame, multi-channel extrema tracker for the histogram-equalization pipeline. For every channel of a pixel stream it finds the minimum and maximum pixel value in a frame and how many times each occurs; the minimum occurrence count is the cdfMin term of the equalization formula. Frames are delimited by explicit SOF/EOF strobes. Results are published once per frame on a valid/ready output port, so the LUT-generation stage can consume them while the next frame accumulates.

## Interface
- DATA_WIDTH, 8, bits per channel sample
- NUM_CH, 1, number of parallel channels packed in i_pixel (channel k at bits [k*DATA_WIDTH +: DATA_WIDTH])
- CNT_WIDTH, 19, occurrence-counter width ($clog2(640*480+1)); counters saturate

- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_pixel  in  NUM_CH*DATA_WIDTH  packed channel samples
- i_pixel_valid  in  1  beat qualifier; i_sof/i_eof are ignored when low
- i_sof  in  1  first beat of frame
- i_eof  in  1  last beat of frame
- o_min  out  NUM_CH*DATA_WIDTH  per-channel frame minimum
- o_min_cnt  out  NUM_CH*CNT_WIDTH  per-channel occurrences of o_min (cdfMin)
- o_max  out  NUM_CH*DATA_WIDTH  per-channel frame maximum
- o_max_cnt  out  NUM_CH*CNT_WIDTH  per-channel occurrences of o_max
- o_stats_valid  out  1  published result available
- i_stats_ready  in  1  consumer accepts result
- o_overrun  out  1  one-cycle pulse: unconsumed result overwritten
- o_frame_err  out  1  one-cycle pulse: SOF arrived mid-frame, partial frame discarded

## Operation
- Reset values: state IDLE; all working and output min/max/count registers 0; o_stats_valid, o_overrun and o_frame_err 0.
- FSM states:
  - IDLE: valid beats without SOF are ignored.
  - ACCUM: accumulating a frame.
- A beat means i_pixel_valid=1. Transitions:
  - IDLE, SOF beat: per channel, work_min=work_max=sample and min_cnt=max_cnt=1; go to ACCUM.
  - IDLE, SOF+EOF on the same beat: single-pixel frame; initialise as above, publish, stay IDLE.
  - ACCUM, non-SOF beat, per channel independently:
    - sample<work_min: work_min<=sample, min_cnt<=1.
    - sample==work_min: min_cnt<=min_cnt+1, saturating at 2^CNT_WIDTH-1.
    - The same rules apply mirrored for the max (sample>work_max resets, == increments).
    - A sample equal to both min and max (flat frame) increments both counts.
  - ACCUM, EOF beat: the beat is included in the stats, the result is published, go to IDLE.
  - ACCUM, SOF beat: pulse o_frame_err, discard the partial frame, re-initialise from this beat, stay ACCUM. With SOF+EOF on this beat: publish the single-pixel result and go to IDLE.
- Publish: outputs are loaded with the post-update working values of the EOF beat, and o_stats_valid is set.
- Output handshake:
  - o_stats_valid stays high and outputs stay stable until i_stats_ready=1 while valid.
  - Publish while valid=1 and i_stats_ready=0: outputs are overwritten, valid stays 1, o_overrun pulses.
  - Publish in the same cycle as an accept (valid=1, ready=1): new data, valid stays 1, no overrun.
  - Accept with no publish: valid drops to 0; outputs hold their last values.
- Channels never interact; the FSM and handshake are shared.
- Reset mid-frame: the partial frame is lost, outputs are cleared, and the block waits for the next SOF.

## Timing
- Accumulation is single-cycle per beat; back-to-back beats every cycle are supported; no backpressure on the input.
- o_stats_valid and the outputs update on the clock edge that samples the EOF beat, i.e. they are visible one cycle after EOF is presented.
- o_overrun and o_frame_err are high for exactly one cycle, in the cycle after the triggering beat.
- Gaps (i_pixel_valid=0) inside a frame hold all state.

## Test plan
- Frame, NUM_CH=1: pixels 5,3,3,9,9,9,EOF on last. Required response: o_min=3, o_min_cnt=2, o_max=9, o_max_cnt=3, valid one cycle after EOF, held until ready.
- NUM_CH=3, 4-beat frame: ch0 = 7,7,7,7; ch1 = 0,255,0,1; ch2 = 10,2,2,200. Required response per channel (min/cnt, max/cnt): ch0 7/4, 7/4; ch1 0/2, 255/1; ch2 2/2, 200/1.
- Two frames with i_stats_ready=0 throughout. Required response: second publish overwrites the first, o_overrun pulses once, valid stays 1.
  - Repeat with ready=1 in the second publish cycle: o_overrun stays 0.
- SOF at beat 3 of an unfinished frame (1,2,SOF 50,60,EOF 40). Required response: o_frame_err pulse; result min=40/1, max=60/1.
- SOF+EOF single beat of 128. Required response: min=max=128, counts=1; beats before any SOF are ignored.
- CNT_WIDTH=3, 10 identical pixels. Required response: counts saturate at 7.
  - Then assert reset mid-frame and send a new 2-pixel frame: clean result.
